// File: rtl/otdr_meas_pkg.sv
// Shared types and defaults for the OTDR timing-measurement blocks.
// Holds the period-meter FSM state enum and the default counter width and
// timeout constant. TIMEOUT_DEF is the same value as the square-wave divider's
// PERIOD default: 2 s at 156.25 MHz.
// Optional build macro SQUARE_METER_DEGLITCH_EN adds the deglitch-length default.
package otdr_meas_pkg;

    localparam int unsigned CNT_W_DEF       = 32;
    localparam logic [31:0] TIMEOUT_DEF     = 32'd312500000;
    localparam int unsigned SYNC_STAGES_DEF = 2;
`ifdef SQUARE_METER_DEGLITCH_EN
    localparam int unsigned DEGLITCH_N_DEF  = 4;
`endif

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARM     = 2'd1,
        MEASURE = 2'd2
    } meter_state_t;

endpackage

// File: rtl/edge_sync.sv
// Synchroniser and edge detector for an asynchronous square wave.
// The input is synchronised through SYNC_STAGES flops. The synchronised level
// feeds a level register, and registered one-cycle rise/fall pulses come out
// SYNC_STAGES+1 cycles after the pin edge.
// With SQUARE_METER_DEGLITCH_EN defined, a level change is accepted only after
// DEGLITCH_N consecutive equal samples. This adds DEGLITCH_N cycles to both edges.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   din         asynchronous input level
//   rise, fall  one-cycle pulses on the accepted level's edges
module edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
`ifdef SQUARE_METER_DEGLITCH_EN
    , parameter int unsigned DEGLITCH_N = 4
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   lvl;
    logic                   lvl_d;

    // Metastability synchroniser; sync_q[SYNC_STAGES-1] is the safe sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};
        end
    end

`ifdef SQUARE_METER_DEGLITCH_EN
    localparam int unsigned DG_W = $clog2(DEGLITCH_N + 1);

    logic [DG_W-1:0] dg_cnt;
    logic            filt_q;

    // Count consecutive samples that differ from the accepted level; any
    // agreeing sample restarts the count, so short pulses never reach N.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dg_cnt <= '0;
            filt_q <= 1'b0;
        end else if (sync_q[SYNC_STAGES-1] == filt_q) begin
            dg_cnt <= '0;
        end else if (dg_cnt == DG_W'(DEGLITCH_N - 1)) begin
            filt_q <= sync_q[SYNC_STAGES-1];
            dg_cnt <= '0;
        end else begin
            dg_cnt <= dg_cnt + 1'b1;
        end
    end

    assign lvl = filt_q;
`else
    assign lvl = sync_q[SYNC_STAGES-1];
`endif

    // Registered edge pulses from the accepted level.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lvl_d <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            lvl_d <= lvl;
            rise  <= lvl & ~lvl_d;
            fall  <= ~lvl & lvl_d;
        end
    end

endmodule

// File: rtl/square_period_meter.sv
// Square-wave period / high-time meter, counted in clk cycles.
// The first rising edge after arming only aligns the counter. Each following
// rise publishes the period (rise-to-rise) and the high time (rise-to-fall),
// with a one-cycle meas_valid pulse.
// A sticky timeout flag is set when no rise arrives within TIMEOUT cycles.
// Optional build macro SQUARE_METER_DEGLITCH_EN enables the input deglitch filter.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   square_in   asynchronous square wave under test
//   meas_en     1 = measure, 0 = idle with results held
//   period_out  last complete period in clk cycles
//   high_out    high time of that period in clk cycles
//   meas_valid  one-cycle pulse when the results update
//   timeout     sticky no-rise flag, cleared by the next meas_valid
module square_period_meter
    import otdr_meas_pkg::*;
#(
    parameter int unsigned      CNT_W       = CNT_W_DEF,
    parameter logic [CNT_W-1:0] TIMEOUT     = CNT_W'(TIMEOUT_DEF),
    parameter int unsigned      SYNC_STAGES = SYNC_STAGES_DEF
`ifdef SQUARE_METER_DEGLITCH_EN
    , parameter int unsigned    DEGLITCH_N  = DEGLITCH_N_DEF
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             square_in,
    input  logic             meas_en,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             timeout
);

    meter_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic             hi_seen_q, hi_seen_d;
    logic [CNT_W-1:0] period_d, high_d;
    logic             valid_d, timeout_d;
    logic             rise, fall;
    logic [CNT_W-1:0] cnt_sat_c;
    logic [CNT_W-1:0] cnt_p1_c;

    edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
`ifdef SQUARE_METER_DEGLITCH_EN
        , .DEGLITCH_N(DEGLITCH_N)
`endif
    ) u_edge_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (square_in),
        .rise  (rise),
        .fall  (fall)
    );

    // The counter saturates at TIMEOUT. cnt_p1_c is an interval length that
    // includes the current cycle.
    assign cnt_sat_c = (cnt_q == TIMEOUT) ? cnt_q : cnt_q + 1'b1;
    assign cnt_p1_c  = cnt_q + 1'b1;

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_cnt_q   <= '0;
            hi_seen_q  <= 1'b0;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_cnt_q   <= hi_cnt_d;
            hi_seen_q  <= hi_seen_d;
            period_out <= period_d;
            high_out   <= high_d;
            meas_valid <= valid_d;
            timeout    <= timeout_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_cnt_d  = hi_cnt_q;
        hi_seen_d = hi_seen_q;
        period_d  = period_out;
        high_d    = high_out;
        valid_d   = 1'b0;
        timeout_d = timeout;

        if (!meas_en) begin
            // Disabling abandons the partial period; results and flag hold.
            state_d   = IDLE;
            cnt_d     = '0;
            hi_seen_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = ARM;
                    cnt_d   = '0;
                end
                ARM: begin
                    if (rise) begin
                        // The first rise only aligns; the partial period is dropped.
                        state_d   = MEASURE;
                        cnt_d     = '0;
                        hi_seen_d = 1'b0;
                    end else begin
                        cnt_d = cnt_sat_c;
                        if (cnt_q == TIMEOUT) begin
                            timeout_d = 1'b1;
                        end
                    end
                end
                MEASURE: begin
                    cnt_d = cnt_sat_c;
                    if (fall && !hi_seen_q) begin
                        hi_cnt_d  = cnt_p1_c;
                        hi_seen_d = 1'b1;
                    end
                    if (rise) begin
                        // Rise takes priority over a coincident timeout. With no
                        // fall seen, the whole period counts as high time.
                        period_d  = cnt_p1_c;
                        high_d    = hi_seen_q ? hi_cnt_q : cnt_p1_c;
                        valid_d   = 1'b1;
                        timeout_d = 1'b0;
                        cnt_d     = '0;
                        hi_seen_d = 1'b0;
                    end else if (cnt_q == TIMEOUT) begin
                        state_d   = ARM;
                        timeout_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

endmodule
